// File: rtl/formula_pkg.sv
// Shared types and helpers for the bit-serial adder-formula checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, ADD/SUB mode constants, saturating increment.
package formula_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Increment that sticks at max_v; counters up to 32 bits wide.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// Single-bit full adder used by the serial formula evaluator.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: a_i, b_i (already inverted for SUB), cin_i -> sum_o, cout_o.
module fa_bit_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/adder_formula_seq_checker.sv
// Bit-serial checker of s == a + b (ADD) or s == a - b (SUB), with verdict counters.
// Latency: accept at E0, bits evaluated on E1..E(W+1), out_valid high after E(W+1).
// Backpressure: verdict held in DONE until out_ready; in_ready low until DONE->IDLE.
// Ports: in_valid/in_ready + a/b/s/op in; out_valid/out_ready + pass/first_fail out;
//        pass_cnt/fail_cnt saturating counters, clr_cnt synchronous clear.
module adder_formula_seq_checker
  import formula_pkg::*;
#(
  parameter int W  = 2,
  parameter int CW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           a,
  input  logic [W-1:0]           b,
  input  logic [W:0]             s,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   pass,
  output logic [$clog2(W+1)-1:0] first_fail,
  output logic [CW-1:0]          pass_cnt,
  output logic [CW-1:0]          fail_cnt,
  input  logic                   clr_cnt
);

  localparam int IW = $clog2(W + 1);
  localparam logic [31:0] CNT_MAX = (CW >= 32) ? 32'hFFFF_FFFF
                                               : 32'((64'd1 << CW) - 64'd1);

  state_e          state_q, state_d;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            pass_q;
  logic [IW-1:0]   ff_q;
  // Operands are shifted right each RUN cycle so bit k is always at index 0.
  logic [W-1:0]    a_sh_q;
  logic [W-1:0]    b_sh_q;      // holds b' (already inverted for SUB)
  logic [W:0]      s_sh_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic            mism_q;
  logic [IW-1:0]   ff_run_q;
  logic [CW-1:0]   pass_cnt_q;
  logic [CW-1:0]   fail_cnt_q;

  logic            fa_sum;
  logic            fa_cout;
  logic            last_bit;
  logic            bit_mis;
  logic            accept;

  fa_bit_cell u_fa (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  always_comb begin
    last_bit = (idx_q == IW'(W));
    // At k = W the carry itself is compared against the MSB of s.
    bit_mis  = last_bit ? (carry_q != s_sh_q[0]) : (fa_sum != s_sh_q[0]);
    accept   = (state_q == IDLE) && in_ready_q && in_valid;

    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      pass_q      <= 1'b0;
      ff_q        <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      s_sh_q      <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      mism_q      <= 1'b0;
      ff_run_q    <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == IDLE);

      case (state_q)
        IDLE: begin
          if (accept) begin
            a_sh_q   <= a;
            b_sh_q   <= (op == OP_SUB) ? ~b : b;
            s_sh_q   <= s;
            carry_q  <= op;      // SUB adds the +1 of two's complement as carry-in
            idx_q    <= '0;
            mism_q   <= 1'b0;
            ff_run_q <= '0;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          s_sh_q  <= s_sh_q >> 1;
          carry_q <= fa_cout;
          idx_q   <= idx_q + IW'(1);
          if (bit_mis && !mism_q) begin
            mism_q   <= 1'b1;
            ff_run_q <= idx_q;
          end
          if (last_bit) begin
            out_valid_q <= 1'b1;
            pass_q      <= !(mism_q || bit_mis);
            ff_q        <= mism_q ? ff_run_q : (bit_mis ? idx_q : '0);
          end
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase

      // Clear has priority over a coincident increment.
      if (clr_cnt) begin
        pass_cnt_q <= '0;
        fail_cnt_q <= '0;
      end else if (state_q == RUN && last_bit) begin
        if (mism_q || bit_mis) fail_cnt_q <= CW'(sat_inc(32'(fail_cnt_q), CNT_MAX));
        else                   pass_cnt_q <= CW'(sat_inc(32'(pass_cnt_q), CNT_MAX));
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign pass       = pass_q;
  assign first_fail = ff_q;
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_adder_formula_seq_checker.sv
// Testbench: two checker instances (W=2/CW=16 and W=4/CW=2) against an arithmetic model.
module tb_adder_formula_seq_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance d2: W=2, CW=16
  logic       iv2 = 0, op2 = 0, or2 = 0, clr2 = 0;
  logic [1:0] a2 = 0, b2 = 0;
  logic [2:0] s2 = 0;
  logic       ir2, ov2, pass2;
  logic [1:0] ff2;
  logic [15:0] pc2, fc2;

  // Instance d4: W=4, CW=2
  logic       iv4 = 0, op4 = 0, or4 = 0, clr4 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic [4:0] s4 = 0;
  logic       ir4, ov4, pass4;
  logic [2:0] ff4;
  logic [1:0] pc4, fc4;

  adder_formula_seq_checker #(.W(2), .CW(16)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .s(s2),
    .op(op2), .out_valid(ov2), .out_ready(or2), .pass(pass2), .first_fail(ff2),
    .pass_cnt(pc2), .fail_cnt(fc2), .clr_cnt(clr2));

  adder_formula_seq_checker #(.W(4), .CW(2)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .s(s4),
    .op(op4), .out_valid(ov4), .out_ready(or4), .pass(pass4), .first_fail(ff4),
    .pass_cnt(pc4), .fail_cnt(fc4), .clr_cnt(clr4));

  int checks = 0;
  int failures = 0;
  int mpc[2];
  int mfc[2];

  localparam int O_IR = 0, O_OV = 1, O_PASS = 2, O_FF = 3, O_PC = 4, O_FC = 5;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] obs(input int w, input int f);
    logic [31:0] r;
    r = '0;
    if (w == 2) begin
      case (f)
        O_IR:   r = 32'(ir2);
        O_OV:   r = 32'(ov2);
        O_PASS: r = 32'(pass2);
        O_FF:   r = 32'(ff2);
        O_PC:   r = 32'(pc2);
        default: r = 32'(fc2);
      endcase
    end else begin
      case (f)
        O_IR:   r = 32'(ir4);
        O_OV:   r = 32'(ov4);
        O_PASS: r = 32'(pass4);
        O_FF:   r = 32'(ff4);
        O_PC:   r = 32'(pc4);
        default: r = 32'(fc4);
      endcase
    end
    return r;
  endfunction

  task automatic drive(input int w, input logic iv, input logic [3:0] a, input logic [3:0] b,
                       input logic [4:0] s, input logic op);
    if (w == 2) begin
      iv2 = iv; a2 = a[1:0]; b2 = b[1:0]; s2 = s[2:0]; op2 = op;
    end else begin
      iv4 = iv; a4 = a; b4 = b; s4 = s; op4 = op;
    end
  endtask

  task automatic set_or(input int w, input logic v);
    if (w == 2) or2 = v; else or4 = v;
  endtask

  task automatic set_clr(input int w, input logic v);
    if (w == 2) clr2 = v; else clr4 = v;
  endtask

  // Expected W+1-bit result of the formula: a+b, or a + (2^W - b) for SUB.
  function automatic int formula(input int w, input int a, input int b, input logic op);
    return op ? (a + (1 << w) - b) : (a + b);
  endfunction

  task automatic send(input int w, input logic [3:0] a, input logic [3:0] b, input logic [4:0] s,
                      input logic op, input int hold, input bit clr_done, input string tag);
    int ia, ib, sv, ex, x, ef, n, cmax, ix;
    bit ep;
    ia = int'(a) & ((1 << w) - 1);
    ib = int'(b) & ((1 << w) - 1);
    sv = int'(s) & ((1 << (w + 1)) - 1);
    ex = formula(w, ia, ib, op);
    x  = sv ^ ex;
    ep = (x == 0);
    ef = 0;
    for (int k = w; k >= 0; k--) if (((x >> k) & 1) == 1) ef = k;
    ix   = (w == 2) ? 0 : 1;
    cmax = (w == 2) ? 65535 : 3;
    if (clr_done) begin
      mpc[ix] = 0; mfc[ix] = 0;
    end else if (ep) begin
      if (mpc[ix] < cmax) mpc[ix]++;
    end else begin
      if (mfc[ix] < cmax) mfc[ix]++;
    end

    n = 0;
    while (obs(w, O_IR) != 1 && n < 20) begin step(); n++; end
    chk({tag, "_ready"}, obs(w, O_IR), 1);
    drive(w, 1'b1, a, b, s, op);
    step();                                     // E0
    drive(w, 1'b0, 4'h0, 4'h0, 5'h0, 1'b0);
    chk({tag, "_busy"}, obs(w, O_IR), 0);
    n = 0;
    while (n < 20) begin
      if (clr_done && n == w) set_clr(w, 1'b1);
      step();
      set_clr(w, 1'b0);
      n++;
      if (obs(w, O_OV) == 1) break;
    end
    chk({tag, "_lat"}, n, w + 1);
    chk({tag, "_pass"}, obs(w, O_PASS), 32'(ep));
    chk({tag, "_ff"}, obs(w, O_FF), ef);
    chk({tag, "_pc"}, obs(w, O_PC), mpc[ix]);
    chk({tag, "_fc"}, obs(w, O_FC), mfc[ix]);
    for (int k = 0; k < hold; k++) begin
      drive(w, (k % 2 == 0), 4'($urandom), 4'($urandom), 5'($urandom), 1'($urandom));
      step();
      chk({tag, "_hold_ov"}, obs(w, O_OV), 1);
      chk({tag, "_hold_ir"}, obs(w, O_IR), 0);
      chk({tag, "_hold_pass"}, obs(w, O_PASS), 32'(ep));
      chk({tag, "_hold_ff"}, obs(w, O_FF), ef);
      chk({tag, "_hold_cnt"}, obs(w, O_PC) + (obs(w, O_FC) << 16), mpc[ix] + (mfc[ix] << 16));
    end
    drive(w, 1'b0, 4'h0, 4'h0, 5'h0, 1'b0);
    set_or(w, 1'b1);
    step();
    set_or(w, 1'b0);
    chk({tag, "_ov_drop"}, obs(w, O_OV), 0);
    chk({tag, "_ir_back"}, obs(w, O_IR), 1);
  endtask

  initial begin
    int w, ia, ib, n;
    logic op;
    logic [4:0] sv;
    mpc[0] = 0; mpc[1] = 0; mfc[0] = 0; mfc[1] = 0;

    // Reset state
    #12;
    chk("rst_ir2", 32'(ir2), 0);
    chk("rst_ov2", 32'(ov2), 0);
    chk("rst_pass2", 32'(pass2), 0);
    chk("rst_ff2", 32'(ff2), 0);
    chk("rst_cnt4", 32'({pc4, fc4}), 0);
    rst_n = 1'b1;
    step();
    chk("rel_ir2", 32'(ir2), 1);
    chk("rel_ir4", 32'(ir4), 1);

    // Directed cases
    send(2, 4'd3, 4'd1, 5'b00100, 1'b0, 0, 1'b0, "add_ok");
    send(2, 4'd3, 4'd1, 5'b00000, 1'b0, 0, 1'b0, "add_msb");
    send(2, 4'd3, 4'd1, 5'b00101, 1'b0, 0, 1'b0, "add_lsb");
    send(4, 4'd5, 4'd7, 5'b01110, 1'b1, 0, 1'b0, "sub_borrow");
    send(4, 4'd7, 4'd5, 5'b10010, 1'b1, 0, 1'b0, "sub_noborrow");
    send(2, 4'd2, 4'd1, 5'b00011, 1'b0, 10, 1'b0, "bp");

    // Saturation on the CW=2 instance, then clear coinciding with an increment
    for (int i = 0; i < 5; i++) send(4, 4'd9, 4'd4, 5'd13, 1'b0, 0, 1'b0, "sat");
    chk("sat_pc", 32'(pc4), 3);
    send(4, 4'd9, 4'd4, 5'd12, 1'b0, 0, 1'b0, "pre_clr");
    send(4, 4'd9, 4'd4, 5'd13, 1'b0, 0, 1'b1, "clr_inc");
    chk("clr_both", 32'({pc4, fc4}), 0);

    // Reset while d2 is in RUN on bit 1
    n = 0;
    while (!ir2 && n < 20) begin step(); n++; end
    drive(2, 1'b1, 4'd1, 4'd1, 5'd2, 1'b0);
    step();
    drive(2, 1'b0, 4'h0, 4'h0, 5'h0, 1'b0);
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ir", 32'(ir2), 0);
    chk("mid_rst_ov", 32'(ov2), 0);
    chk("mid_rst_pass", 32'(pass2), 0);
    chk("mid_rst_ff", 32'(ff2), 0);
    chk("mid_rst_cnt2", 32'(pc2) + (32'(fc2) << 16), 0);
    chk("mid_rst_cnt4", 32'({pc4, fc4}), 0);
    mpc[0] = 0; mpc[1] = 0; mfc[0] = 0; mfc[1] = 0;
    step();
    chk("in_rst_ov", 32'(ov2), 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ir", 32'(ir2), 1);
    send(2, 4'd1, 4'd2, 5'd3, 1'b0, 0, 1'b0, "post_rst");
    chk("post_rst_pc", 32'(pc2), 1);

    // Randomized transactions on both instances
    for (int i = 0; i < 60; i++) begin
      w  = (i % 2 == 0) ? 2 : 4;
      ia = $urandom_range(0, (1 << w) - 1);
      ib = $urandom_range(0, (1 << w) - 1);
      op = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) sv = 5'(formula(w, ia, ib, op));
      else sv = 5'($urandom_range(0, (1 << (w + 1)) - 1));
      send(w, 4'(ia), 4'(ib), sv, op, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_formula_seq_checker.md
# adder_formula_seq_checker

Sequential, parametrised checker for the adder-relation formulas in our Skolem benchmark set. It accepts one assignment per handshake: operands `a`, `b`, candidate result `s` and a mode bit. It evaluates the formula `s == a + b` (ADD) or `s == a - b` (SUB, two's complement) bit-serially, LSB first, and reports pass/fail, the first failing bit, and running pass/fail counts. It sits between the assignment stimulus generator and the results logger, replacing fixed 2-bit combinational formula instances.

## Interface
Parameters:
- `W`, default 2: operand width; candidate `s` is `W+1` bits.
- `CW`, default 16: width of the pass/fail counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  assignment offered.
- `in_ready`  out  1  block can accept an assignment.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `s`  in  W+1  candidate result; MSB is the carry (ADD) or carry-out of `a + ~b + 1` (SUB).
- `op`  in  1  mode: 0 = ADD, 1 = SUB.
- `out_valid`  out  1  verdict available.
- `out_ready`  in  1  downstream takes the verdict.
- `pass`  out  1  1 = formula satisfied.
- `first_fail`  out  $clog2(W+1)  index of the lowest mismatching bit; 0 when `pass`=1.
- `pass_cnt`  out  CW  saturating count of passing verdicts.
- `fail_cnt`  out  CW  saturating count of failing verdicts.
- `clr_cnt`  in  1  synchronous clear of both counters.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `in_ready`=1. On `in_valid & in_ready`, latch `a`, `b`, `s`, `op`. Set the carry register to `op`, the bit index to 0 and the mismatch flag to 0, then go to RUN.
  - RUN: one bit per cycle.
    - For k < W: sum_k = a[k] ^ b'[k] ^ carry, where b' = `op` ? ~b : b. Compare sum_k with s[k], then update carry = maj(a[k], b'[k], carry).
    - For k = W: compare the final carry with s[W].
    - On the first mismatch, record k in `first_fail`. Later mismatches do not overwrite it.
    - After the k = W compare, go to DONE.
  - DONE: `out_valid`=1; `pass` and `first_fail` are held stable. On `out_ready`, go to IDLE.
- The counters update on the cycle of the RUN→DONE transition: `pass_cnt`++ if no mismatch, otherwise `fail_cnt`++. Both saturate at 2^CW−1.
- `clr_cnt` zeroes both counters. If it coincides with an increment, the clear wins and the result is 0.
- RUN never terminates early; latency is constant regardless of the data.
- Inputs are ignored outside the IDLE accept cycle.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0 and 1 after release (IDLE); `out_valid`=0, `pass`=0, `first_fail`=0, `pass_cnt`=0, `fail_cnt`=0.
- Latency:
  - Accept at edge E0.
  - RUN occupies edges E1..E(W+1).
  - `out_valid` is high from after E(W+1).
- Throughput:
  - The DONE→IDLE transition occurs on the edge where `out_ready`=1.
  - The next accept is no earlier than the following edge.
  - Minimum spacing is W+3 cycles.
- `out_valid` is held with stable data until `out_ready`. `out_ready` asserted while `out_valid`=0 has no effect.
- Asserting `rst_n`=0 in any state (including mid-RUN) returns the block to IDLE. The partial result is discarded, counters are zeroed and nothing is emitted.
- SUB carry convention: s[W]=1 means no borrow (a ≥ b unsigned).

## Structure
- Shared package `formula_pkg`: FSM state enum (IDLE/RUN/DONE), `OP_ADD`/`OP_SUB` constants, saturating-increment function.
- One natural sub-module: `fa_bit_cell`, a combinational full adder giving sum/carry from `a`, `b'`, `cin`. The top module holds the FSM, shift/index, carry and mismatch registers, and the counters.

## Test plan
- W=2, ADD, a=2'b11, b=2'b01, s=3'b100 → `pass`=1, `first_fail`=0, `out_valid` 3 cycles after accept, `pass_cnt`=1.
- W=2, ADD, a=3, b=1, s=3'b000 → `pass`=0, `first_fail`=2, `fail_cnt`=1. Then s=3'b101 → `pass`=0, `first_fail`=0.
- W=4, SUB, a=5, b=7, s=5'b0_1110 → `pass`=1 (borrow, s[4]=0). Then a=7, b=5, s=5'b1_0010 → `pass`=1.
- Backpressure: `out_ready`=0 for 10 cycles → `out_valid`, `pass` and `first_fail` stay stable and `in_ready`=0. `in_valid` pulses during that window are not accepted and the counters are unchanged.
- Set CW=2 and send 5 passing assignments → `pass_cnt` sticks at 3. Assert `clr_cnt` on the same cycle as an increment → both counters read 0.
- Drop `rst_n` at RUN bit 1 → all outputs zero immediately. After release, `in_ready`=1, a fresh assignment completes normally and `pass_cnt`=1.
